photon_event_tagger: RTL and testbench
======================================

// Module: photon_event_tagger
// PURPOSE
//  Write-side producer for the dual-clock FIFO. Detects rising edges on pre-synchronised
//  detector lines and timestamps them against a free-running counter. Packs each event
//  into one INT_FIFO_WIDTH word on a valid/ready stream. Also inserts timer-rollover
//  markers and dropped-event reports, so the read side can rebuild absolute time and
//  account for losses.
// PARAMETERS
//  INT_FIFO_WIDTH    32  output word width; must equal the downstream FIFO width
//  INT_CHANNELS      4   detector channels; INT_CHANNELS <= INT_FIFO_WIDTH-8
//  INT_DEADTIME_CLKS 8   per-channel dead time in clocks (used only with the optional feature)
// PORTS
//  wr_clk        in   1   sole clock (FIFO write domain)
//  wr_rst_n      in   1   asynchronous, active-low reset
//  i_det         in   INT_CHANNELS  detector levels, already synchronised to wr_clk
//  i_en          in   1   1: capture events; 0: ignore edges (timer and rollover keep running)
//  o_data        out  INT_FIFO_WIDTH  packed word
//  o_valid       out  1   o_data valid
//  i_ready       in   1   downstream (FIFO o_ready) accepts the word
//  o_drop_sticky out  1   set on any dropped event; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release): o_valid=0, o_data=0, o_drop_sticky=0, ts=0,
//   roll_cnt=0, drop_cnt=0, roll_pend=0. det_q resets to all ones, so a line already high
//   at release makes no event. Reset mid-transfer discards the held word.
//  Timer: ts is TS_W = INT_FIFO_WIDTH-2-INT_CHANNELS bits; +1 every clock; wraps to 0.
//   When ts == all-ones, roll_pend is set on the next edge and roll_cnt increments (mod 2^30).
//  Edge detect: rise = i_det & ~det_q & {INT_CHANNELS{i_en}}; det_q <= i_det each clock.
//  Word formats, bits [W-1:W-2] = type:
//   2'b01 EVENT: [W-3 -: INT_CHANNELS] = rise mask; [TS_W-1:0] = ts of the detect cycle.
//   2'b10 ROLL:  [29:0] = roll_cnt after increment.
//   2'b11 DROP:  [15:0] = drop_cnt; all other bits 0.
//  Handshake: transfer when o_valid & i_ready. While o_valid & ~i_ready, o_data is held
//   stable. slot_free = ~o_valid | i_ready.
//  Output FSM, evaluated each clock when slot_free:
//   priority ROLL (roll_pend) > DROP (drop_cnt!=0) > EVENT (rise!=0) > IDLE (o_valid<=0).
//   Loading ROLL clears roll_pend. Loading DROP clears drop_cnt.
//  Latency: edge in cycle k -> EVENT on o_data with o_valid=1 in cycle k+1 (slot free,
//   nothing of higher priority pending).
//  Drop rule: any rise!=0 that is not loaded in its cycle (slot busy, or pre-empted by ROLL
//   or DROP) is one drop. drop_cnt += 1, saturating at 16'hFFFF; o_drop_sticky <= 1.
//   If a drop and a DROP load happen in the same cycle, drop_cnt <= 1.
//  Simultaneous edges on several channels -> one EVENT with a multi-bit mask.
//  Events are never reordered; the rollover wrap ordering is fixed by ROLL priority.
// CONFIGURATION
//  PHOTON_TAGGER_DEADTIME_EN defined:
//   - per-channel down-counter loads INT_DEADTIME_CLKS on that channel's rise;
//   - while nonzero, that channel's rise bit is masked (not counted as a drop).
//  Undefined: no dead-time logic; every edge is eligible.
// STRUCTURE
//  photon_tagger_pkg: type codes (TYPE_EVENT, TYPE_ROLL, TYPE_DROP), DROP_CNT_W=16,
//   ROLL_CNT_W=30, TS_W function of the parameters.
//  Sub-module photon_tagger_deadtime (one instance per channel, generate loop); present
//   only under PHOTON_TAGGER_DEADTIME_EN.
//  Top: timer, edge detect, drop counter, output FSM/register.
// TESTING
//  1 Reset with i_det=4'b0001 held, release -> no EVENT; ts=0 in the first cycle after release.
//  2 i_ready=1; pulse ch2 at ts=100 -> next cycle o_valid=1,
//    o_data={2'b01,4'b0100,26'd100}; ch0+ch3 together -> mask 4'b1001.
//  3 i_ready=0 with EVENT held; 3 further edges -> o_data stable, o_drop_sticky=1;
//    i_ready=1 -> DROP word 16'd3, then next event.
//  4 Force ts to all-ones-1 (TS_W=26) with an edge in the wrap cycle -> ROLL word roll_cnt=1
//    before the EVENT; the pre-empted edge counts as drop=1.
//  5 With PHOTON_TAGGER_DEADTIME_EN, INT_DEADTIME_CLKS=8: edges on ch1 at t and t+4 -> one
//    EVENT; edge at t+9 -> second EVENT. Without the macro -> 2 EVENTs for t and t+4.
//  6 Random i_det/i_ready, 1e5 cycles: scoreboard checks EVENT + drop counts = total edges,
//    no o_data change while stalled, and async reset mid-stall -> o_valid=0 immediately.

Source files
------------

// File: rtl/photon_tagger_pkg.sv
// Shared word-type codes, counter widths and timestamp-width helper for the photon event tagger.
package photon_tagger_pkg;

    typedef enum logic [1:0] {
        TYPE_IDLE  = 2'b00,
        TYPE_EVENT = 2'b01,
        TYPE_ROLL  = 2'b10,
        TYPE_DROP  = 2'b11
    } word_type_e;

    localparam int DROP_CNT_W = 16;
    localparam int ROLL_CNT_W = 30;

    // Timestamp fills whatever the type field and channel mask leave of the word.
    function automatic int ts_width(input int fifo_w, input int channels);
        return fifo_w - 2 - channels;
    endfunction

endpackage

// File: rtl/photon_tagger_deadtime.sv
// Per-channel dead-time filter: after an accepted rise, further rises on this channel are
// masked for INT_DEADTIME_CLKS clocks. Instantiated only under PHOTON_TAGGER_DEADTIME_EN.
module photon_tagger_deadtime #(
    parameter int INT_DEADTIME_CLKS = 8
) (
    input  logic wr_clk,
    input  logic wr_rst_n,
    input  logic rise_i,
    output logic rise_o
);
    localparam int CNT_W = $clog2(INT_DEADTIME_CLKS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;

    assign busy   = (cnt_q != '0);
    assign rise_o = rise_i & ~busy;

    always_comb begin
        cnt_d = cnt_q;
        if (rise_o)
            cnt_d = CNT_W'(INT_DEADTIME_CLKS);
        else if (busy)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/photon_event_tagger.sv
// Photon event tagger: timestamps detector rising edges and emits EVENT/ROLL/DROP words on a
// valid/ready stream. Optional per-channel dead time via PHOTON_TAGGER_DEADTIME_EN.
//   state      | meaning
//   TYPE_IDLE  | output register empty (o_valid=0)
//   TYPE_EVENT | holding an edge mask + timestamp
//   TYPE_ROLL  | holding a timer-rollover marker
//   TYPE_DROP  | holding a dropped-event count
module photon_event_tagger
    import photon_tagger_pkg::*;
#(
    parameter int INT_FIFO_WIDTH    = 32,
    parameter int INT_CHANNELS      = 4,
    parameter int INT_DEADTIME_CLKS = 8
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst_n,
    input  logic [INT_CHANNELS-1:0]   i_det,
    input  logic                      i_en,
    output logic [INT_FIFO_WIDTH-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_drop_sticky
);
    localparam int TS_W = ts_width(INT_FIFO_WIDTH, INT_CHANNELS);

    logic [TS_W-1:0]           ts_q;
    logic [ROLL_CNT_W-1:0]     roll_cnt_q, roll_cnt_d;
    logic                      roll_pend_q, roll_pend_d;
    logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic                      drop_sticky_q;
    logic [INT_CHANNELS-1:0]   det_q, rise_raw, rise;
    logic [INT_FIFO_WIDTH-1:0] data_q, ev_word, roll_word, drop_word;
    word_type_e                state_q;
    logic                      slot_free, load_roll, load_drop, load_event, drop;

    assign rise_raw = i_det & ~det_q & {INT_CHANNELS{i_en}};

`ifdef PHOTON_TAGGER_DEADTIME_EN
    for (genvar g = 0; g < INT_CHANNELS; g++) begin : g_dt
        photon_tagger_deadtime #(
            .INT_DEADTIME_CLKS(INT_DEADTIME_CLKS)
        ) u_deadtime (
            .wr_clk  (wr_clk),
            .wr_rst_n(wr_rst_n),
            .rise_i  (rise_raw[g]),
            .rise_o  (rise[g])
        );
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = ^INT_DEADTIME_CLKS;
    assign rise = rise_raw;
`endif

    assign slot_free  = (state_q == TYPE_IDLE) | i_ready;
    assign load_roll  = slot_free & roll_pend_q;
    assign load_drop  = slot_free & ~roll_pend_q & (drop_cnt_q != '0);
    assign load_event = slot_free & ~roll_pend_q & (drop_cnt_q == '0) & (rise != '0);
    // Any eligible edge not captured this cycle is lost and must be accounted for.
    assign drop       = (rise != '0) & ~load_event;

    always_comb begin
        ev_word   = '0;
        roll_word = '0;
        drop_word = '0;
        ev_word[INT_FIFO_WIDTH-1 -: 2]            = TYPE_EVENT;
        ev_word[INT_FIFO_WIDTH-3 -: INT_CHANNELS] = rise;
        ev_word[TS_W-1:0]                         = ts_q;
        roll_word[INT_FIFO_WIDTH-1 -: 2]          = TYPE_ROLL;
        roll_word[ROLL_CNT_W-1:0]                 = roll_cnt_q;
        drop_word[INT_FIFO_WIDTH-1 -: 2]          = TYPE_DROP;
        drop_word[DROP_CNT_W-1:0]                 = drop_cnt_q;
    end

    always_comb begin
        roll_cnt_d  = roll_cnt_q;
        roll_pend_d = roll_pend_q;
        if (load_roll)
            roll_pend_d = 1'b0;
        if (ts_q == '1) begin
            roll_pend_d = 1'b1;
            roll_cnt_d  = roll_cnt_q + 1'b1;
        end
        drop_cnt_d = drop_cnt_q;
        if (load_drop)
            drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
        else if (drop && drop_cnt_q != '1)
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            ts_q          <= '0;
            roll_cnt_q    <= '0;
            roll_pend_q   <= 1'b0;
            drop_cnt_q    <= '0;
            drop_sticky_q <= 1'b0;
            det_q         <= '1;
        end else begin
            ts_q          <= ts_q + 1'b1;
            roll_cnt_q    <= roll_cnt_d;
            roll_pend_q   <= roll_pend_d;
            drop_cnt_q    <= drop_cnt_d;
            drop_sticky_q <= drop_sticky_q | drop;
            det_q         <= i_det;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q <= TYPE_IDLE;
            data_q  <= '0;
        end else if (slot_free) begin
            if (load_roll) begin
                state_q <= TYPE_ROLL;
                data_q  <= roll_word;
            end else if (load_drop) begin
                state_q <= TYPE_DROP;
                data_q  <= drop_word;
            end else if (load_event) begin
                state_q <= TYPE_EVENT;
                data_q  <= ev_word;
            end else begin
                state_q <= TYPE_IDLE;
            end
        end
    end

    assign o_data        = data_q;
    assign o_valid       = (state_q != TYPE_IDLE);
    assign o_drop_sticky = drop_sticky_q;

endmodule

// File: tb/tb_photon_event_tagger.sv
// Directed bench for photon_event_tagger: reset, event packing, stall/drop, rollover on a
// narrow-timestamp instance, dead time, async reset mid-stall and a random accounting run.
module tb_photon_event_tagger;

    logic        wr_clk = 1'b0;
    logic        wr_rst_n = 1'b0;
    logic        rst_r_n = 1'b0;
    logic [3:0]  i_det = 4'b0001;
    logic        i_en = 1'b1;
    logic        i_ready = 1'b1;
    logic [31:0] o_data;
    logic        o_valid, o_drop_sticky;

    logic [19:0] det_r = '0;
    logic        ready_r = 1'b1;
    logic [31:0] data_r;
    logic        valid_r, sticky_r;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 wr_clk = ~wr_clk;

    photon_event_tagger #(
        .INT_FIFO_WIDTH(32), .INT_CHANNELS(4), .INT_DEADTIME_CLKS(8)
    ) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .i_det(i_det), .i_en(i_en),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_drop_sticky(o_drop_sticky)
    );

    // 20 channels leave a 10-bit timestamp, so rollover is reachable in ~1k cycles.
    photon_event_tagger #(
        .INT_FIFO_WIDTH(32), .INT_CHANNELS(20), .INT_DEADTIME_CLKS(8)
    ) dut_r (
        .wr_clk(wr_clk), .wr_rst_n(rst_r_n), .i_det(det_r), .i_en(1'b1),
        .o_data(data_r), .o_valid(valid_r), .i_ready(ready_r), .o_drop_sticky(sticky_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge wr_clk);
            cyc++;
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] m, input int t);
        logic [31:0] tt;
        tt = t;
        return {2'b01, m, tt[25:0]};
    endfunction

    function automatic logic [31:0] ev_r(input logic [19:0] m, input int t);
        logic [31:0] tt;
        tt = t;
        return {2'b01, m, tt[9:0]};
    endfunction

    initial begin
        logic [3:0]  prev, r;
        logic [31:0] held;
        logic        stalled;
        int          dtc[4];
        int          edges, evs, drops, stall_viol;

        repeat (3) @(negedge wr_clk);
        chk("in_reset_valid", {31'b0, o_valid}, 32'd0);
        wr_rst_n = 1'b1;
        rst_r_n  = 1'b1;
        cyc = 0;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_sticky", {31'b0, o_drop_sticky}, 32'd0);
        chk("rst_ts", 32'(dut.ts_q), 32'd0);

        tick(1);
        chk("held_high_no_event", {31'b0, o_valid}, 32'd0);
        i_det = 4'b0000;
        tick(1);
        chk("fall_no_event", {31'b0, o_valid}, 32'd0);

        tick(98);
        i_det = 4'b0100;
        tick(1);
        chk("ev_ch2_valid", {31'b0, o_valid}, 32'd1);
        chk("ev_ch2_data", o_data, ev(4'b0100, 100));
        i_det = 4'b0000;
        tick(1);
        chk("idle_after_xfer", {31'b0, o_valid}, 32'd0);
        i_det = 4'b1001;
        tick(1);
        chk("ev_multi_data", o_data, ev(4'b1001, 102));

        i_det   = 4'b0000;
        i_ready = 1'b0;
        tick(1);
        chk("stall_hold_1", o_data, ev(4'b1001, 102));
        i_det = 4'b0001;
        tick(1);
        chk("stall_sticky", {31'b0, o_drop_sticky}, 32'd1);
        i_det = 4'b0011;
        tick(1);
        i_det = 4'b0111;
        tick(1);
        chk("stall_hold_2", o_data, ev(4'b1001, 102));
        chk("stall_valid", {31'b0, o_valid}, 32'd1);
        i_ready = 1'b1;
        tick(1);
        chk("drop_word", o_data, {2'b11, 14'b0, 16'd3});
        i_det = 4'b1111;
        tick(1);
        chk("ev_after_drop", o_data, ev(4'b1000, 108));
        i_det = 4'b0000;
        tick(1);
        chk("idle_110", {31'b0, o_valid}, 32'd0);

        i_det = 4'b0010;
        tick(1);
        chk("dt_first", o_data, ev(4'b0010, 110));
        i_det = 4'b0000;
        tick(3);
        i_det = 4'b0010;
        tick(1);
`ifdef PHOTON_TAGGER_DEADTIME_EN
        chk("dt_masked", {31'b0, o_valid}, 32'd0);
`else
        chk("dt_second_valid", {31'b0, o_valid}, 32'd1);
        chk("dt_second", o_data, ev(4'b0010, 114));
`endif
        i_det = 4'b0000;
        tick(4);
        i_det = 4'b0010;
        tick(1);
        chk("dt_third", o_data, ev(4'b0010, 119));
        i_det   = 4'b0000;
        i_ready = 1'b0;
        tick(1);
        chk("pre_reset_stall", {31'b0, o_valid}, 32'd1);
        #3 wr_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_data", o_data, 32'd0);
        chk("async_rst_sticky", {31'b0, o_drop_sticky}, 32'd0);
        tick(1);
        wr_rst_n = 1'b1;
        i_ready  = 1'b1;

        tick(1023 - cyc);
        det_r = 20'h00001;
        tick(1);
        chk("r_ev_last_ts", data_r, ev_r(20'h00001, 1023));
        det_r = 20'h00003;
        tick(1);
        chk("r_roll_word", data_r, {2'b10, 30'd1});
        chk("r_sticky", {31'b0, sticky_r}, 32'd1);
        tick(1);
        chk("r_drop_word", data_r, {2'b11, 14'b0, 16'd1});
        det_r = 20'h00007;
        tick(1);
        chk("r_ev_after_wrap", data_r, ev_r(20'h00004, 1026));
        chk("r_valid", {31'b0, valid_r}, 32'd1);

        prev = i_det;
        foreach (dtc[c]) dtc[c] = 0;
        edges = 0; evs = 0; drops = 0; stall_viol = 0;
        stalled = 1'b0; held = '0;
        for (int n = 0; n < 3006; n++) begin
            if (stalled && (o_valid !== 1'b1 || o_data !== held))
                stall_viol++;
            if (n < 3000) begin
                i_det   = 4'($urandom_range(0, 15));
                i_ready = 1'($urandom_range(0, 1));
                i_en    = ($urandom_range(0, 7) != 0);
            end else begin
                i_ready = 1'b1;
            end
            r = i_det & ~prev & {4{i_en}};
`ifdef PHOTON_TAGGER_DEADTIME_EN
            for (int c = 0; c < 4; c++) begin
                if (dtc[c] != 0) begin
                    r[c] = 1'b0;
                    dtc[c]--;
                end else if (r[c]) begin
                    dtc[c] = 8;
                end
            end
`endif
            if (r != 4'b0)
                edges++;
            prev = i_det;
            if (o_valid && i_ready) begin
                if (o_data[31:30] == 2'b01)
                    evs++;
                else if (o_data[31:30] == 2'b11)
                    drops += int'(o_data[15:0]);
            end
            stalled = o_valid && !i_ready;
            held    = o_data;
            tick(1);
        end
        chk("rand_accounting", evs + drops, edges);
        chk("rand_stall_stable", stall_viol, 0);
        chk("rand_events_seen", {31'b0, (evs > 0)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
